// File: rtl/logic_unit_pipe.sv
// ============================================================================
// Module   : logic_unit_pipe
// Purpose  : WIDTH-bit, eight-operation bitwise logic unit with a registered
//            valid/ready output stage and a one-entry skid buffer.
//            Optional zero/parity flags via `define LOGIC_UNIT_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_unit_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y
`ifdef LOGIC_UNIT_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_parity
`endif
);

  localparam logic [2:0] c_OP_NOT  = 3'd0;
  localparam logic [2:0] c_OP_AND  = 3'd1;
  localparam logic [2:0] c_OP_OR   = 3'd2;
  localparam logic [2:0] c_OP_XOR  = 3'd3;
  localparam logic [2:0] c_OP_NAND = 3'd4;
  localparam logic [2:0] c_OP_NOR  = 3'd5;
  localparam logic [2:0] c_OP_XNOR = 3'd6;

  logic [WIDTH-1:0] w_res;
  logic             w_out_free;
  logic             w_in_xfer;
  logic             w_skid_to_out;
  logic             w_in_to_out;
  logic             w_in_to_skid;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_y;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_y;

  always_comb begin
    w_res = in_a;
    case (in_op)
      c_OP_NOT:  w_res = ~in_a;
      c_OP_AND:  w_res = in_a & in_b;
      c_OP_OR:   w_res = in_a | in_b;
      c_OP_XOR:  w_res = in_a ^ in_b;
      c_OP_NAND: w_res = ~(in_a & in_b);
      c_OP_NOR:  w_res = ~(in_a | in_b);
      c_OP_XNOR: w_res = ~(in_a ^ in_b);
      default:   w_res = in_a;
    endcase
  end

  // in_ready depends only on the skid flop, so out_ready never reaches it
  assign in_ready      = !r_skid_valid;
  assign w_out_free    = !r_out_valid || out_ready;
  assign w_in_xfer     = in_valid && !r_skid_valid;
  assign w_skid_to_out = w_out_free && r_skid_valid;
  assign w_in_to_out   = w_out_free && w_in_xfer;
  assign w_in_to_skid  = !w_out_free && w_in_xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_y      <= '0;
      r_skid_valid <= 1'b0;
      r_skid_y     <= '0;
    end else begin
      if (w_out_free) begin
        r_out_valid <= r_skid_valid || w_in_xfer;
      end
      if (w_skid_to_out) begin
        r_out_y <= r_skid_y;
      end else if (w_in_to_out) begin
        r_out_y <= w_res;
      end
      if (w_skid_to_out) begin
        r_skid_valid <= 1'b0;
      end else if (w_in_to_skid) begin
        r_skid_valid <= 1'b1;
      end
      if (w_in_to_skid) begin
        r_skid_y <= w_res;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_y     = r_out_y;

`ifdef LOGIC_UNIT_FLAGS_EN
  // Flags are evaluated once at the input and travel with the result
  logic [1:0] w_flags;
  logic [1:0] r_out_flags;
  logic [1:0] r_skid_flags;

  assign w_flags = {(w_res == '0), ^w_res};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_flags  <= 2'b00;
      r_skid_flags <= 2'b00;
    end else begin
      if (w_skid_to_out) begin
        r_out_flags <= r_skid_flags;
      end else if (w_in_to_out) begin
        r_out_flags <= w_flags;
      end
      if (w_in_to_skid) begin
        r_skid_flags <= w_flags;
      end
    end
  end

  assign out_zero   = r_out_flags[1];
  assign out_parity = r_out_flags[0];
`endif

endmodule

`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
// ============================================================================
// Module   : tb_logic_unit_pipe
// Purpose  : Scoreboard bench for logic_unit_pipe (WIDTH=16, plus 1/64 builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_logic_unit_pipe;

  typedef struct packed {
    logic [15:0] y;
    logic        z;
    logic        p;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_y;
  logic        out_zero;
  logic        out_parity;

  // narrow / wide builds share a small private stimulus
  logic        w_v;
  logic [2:0]  w_op;
  logic        r1_ready, r64_ready, v1, v64;
  logic [0:0]  y1;
  logic [63:0] y64;
  logic [0:0]  a1;
  logic [63:0] a64;
  logic        z1, p1, z64, p64;

  int   errors = 0;
  int   checks = 0;
  int   pops   = 0;
  exp_t sb[$];
  logic rand_ready = 1'b0;
  logic prev_stall = 1'b0;
  logic [15:0] prev_y = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y)
`ifdef LOGIC_UNIT_FLAGS_EN
    , .out_zero(out_zero), .out_parity(out_parity)
`endif
  );

  logic_unit_pipe #(.WIDTH(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_v), .in_ready(r1_ready),
    .in_op(w_op), .in_a(a1), .in_b(a1), .out_valid(v1),
    .out_ready(1'b1), .out_y(y1)
`ifdef LOGIC_UNIT_FLAGS_EN
    , .out_zero(z1), .out_parity(p1)
`endif
  );

  logic_unit_pipe #(.WIDTH(64)) dut_w64 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_v), .in_ready(r64_ready),
    .in_op(w_op), .in_a(a64), .in_b(a64), .out_valid(v64),
    .out_ready(1'b1), .out_y(y64)
`ifdef LOGIC_UNIT_FLAGS_EN
    , .out_zero(z64), .out_parity(p64)
`endif
  );

`ifndef LOGIC_UNIT_FLAGS_EN
  assign out_zero = 1'b0;
  assign out_parity = 1'b0;
  assign z1 = 1'b0;
  assign p1 = 1'b0;
  assign z64 = 1'b0;
  assign p64 = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Independent reference: per-bit truth table indexed by {a_i, b_i}
  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [3:0] tt;
    exp_t e;
    case (op)
      3'd0: tt = 4'b0011;
      3'd1: tt = 4'b1000;
      3'd2: tt = 4'b1110;
      3'd3: tt = 4'b0110;
      3'd4: tt = 4'b0111;
      3'd5: tt = 4'b0001;
      3'd6: tt = 4'b1001;
      default: tt = 4'b1100;
    endcase
    for (int i = 0; i < 16; i++) e.y[i] = tt[{a[i], b[i]}];
    e.z = (e.y == 16'h0000);
    e.p = ^e.y;
    return e;
  endfunction

  function automatic exp_t mk(input logic [15:0] y, input logic z, input logic p);
    exp_t e;
    e.y = y; e.z = z; e.p = p;
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input exp_t e);
    int n;
    logic acc;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    while (!acc && n < 200) begin
      acc = in_ready;
      if (acc) sb.push_back(e);
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 64'(sb.size()), 64'd0);
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: pops on every output transfer and checks stall stability
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("valid_held_in_stall", 64'(out_valid), 64'd1);
        chk("y_stable_in_stall", 64'(out_y), 64'(prev_y));
      end
      prev_stall <= out_valid && !out_ready;
      prev_y <= out_y;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 64'(out_y), 64'hDEAD_0000);
        end else begin
          exp_t e;
          e = sb.pop_front();
          pops++;
          chk("out_y", 64'(out_y), 64'(e.y));
`ifdef LOGIC_UNIT_FLAGS_EN
          chk("out_zero", 64'(out_zero), 64'(e.z));
          chk("out_parity", 64'(out_parity), 64'(e.p));
`endif
        end
      end
    end
  end

  initial begin
    int p0;
    logic [2:0]  rop;
    logic [15:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    out_ready = 1'b1; w_v = 1'b0; w_op = '0; a1 = 1'b1; a64 = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_y", 64'(out_y), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // WIDTH=1 and WIDTH=64 builds
    w_v = 1'b1; w_op = 3'd7;
    @(posedge clk); #1;
    chk("w1_pass", 64'(y1), 64'd1);
    chk("w64_pass", y64, 64'hFFFF_FFFF_FFFF_FFFF);
    w_op = 3'd4;
    @(posedge clk); #1;
    w_v = 1'b0;
    chk("w1_nand_valid", 64'(v1), 64'd1);
    chk("w1_nand", 64'(y1), 64'd0);
    chk("w64_nand", y64, 64'd0);

    // All ops back to back, a=F0F0 b=FF00
    p0 = pops;
    send(3'd0, 16'hF0F0, 16'hFF00, mk(16'h0F0F, 1'b0, 1'b0));
    chk("latency_valid", 64'(out_valid), 64'd1);
    chk("latency_y", 64'(out_y), 64'h0F0F);
    send(3'd1, 16'hF0F0, 16'hFF00, mk(16'hF000, 1'b0, 1'b0));
    send(3'd2, 16'hF0F0, 16'hFF00, mk(16'hFFF0, 1'b0, 1'b0));
    send(3'd3, 16'hF0F0, 16'hFF00, mk(16'h0FF0, 1'b0, 1'b0));
    send(3'd4, 16'hF0F0, 16'hFF00, mk(16'h0FFF, 1'b0, 1'b0));
    send(3'd5, 16'hF0F0, 16'hFF00, mk(16'h000F, 1'b0, 1'b0));
    send(3'd6, 16'hF0F0, 16'hFF00, mk(16'hF00F, 1'b0, 1'b0));
    send(3'd7, 16'hF0F0, 16'hFF00, mk(16'hF0F0, 1'b0, 1'b0));
    drain("ops_drain");
    chk("ops_count", 64'(pops - p0), 64'd8);

    // Flags
    send(3'd3, 16'h1234, 16'h1234, mk(16'h0000, 1'b1, 1'b0));
    send(3'd0, 16'hFFFE, 16'h5555, mk(16'h0001, 1'b0, 1'b1));
    drain("flags_drain");

    // Back-pressure: fill OUT and SKID, hold off beats 3-4, then release
    p0 = pops;
    out_ready = 1'b0;
    send(3'd1, 16'h00FF, 16'h0F0F, mk(16'h000F, 1'b0, 1'b0));
    send(3'd2, 16'h00FF, 16'h0F0F, mk(16'h0FFF, 1'b0, 1'b0));
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_out_y_first", 64'(out_y), 64'h000F);
    fork
      begin
        send(3'd5, 16'h00FF, 16'h0F0F, mk(16'hF000, 1'b0, 1'b0));
        send(3'd7, 16'h1357, 16'h0000, mk(16'h1357, 1'b0, 1'b0));
      end
      begin
        repeat (3) begin @(posedge clk); #1; end
        chk("bp_held_off", 64'(sb.size()), 64'd2);
        chk("bp_in_ready_still_low", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_in_ready_back", 64'(in_ready), 64'd1);
      end
    join
    drain("bp_drain");
    chk("bp_count", 64'(pops - p0), 64'd4);

    // Reset mid-stream with OUT and SKID full
    out_ready = 1'b0;
    send(3'd6, 16'h0000, 16'h0000, mk(16'hFFFF, 1'b0, 1'b0));
    send(3'd0, 16'h0000, 16'h0000, mk(16'hFFFF, 1'b0, 1'b0));
    chk("pre_rst_in_ready", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_y", 64'(out_y), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_no_output", 64'(out_valid), 64'd0);
    send(3'd7, 16'hABCD, 16'h0000, mk(16'hABCD, 1'b0, 1'b0));
    chk("postrst_latency_valid", 64'(out_valid), 64'd1);
    chk("postrst_latency_y", 64'(out_y), 64'hABCD);
    drain("postrst_drain");

    // Random valid/ready toggling
    p0 = pops;
    rand_ready = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      rop = 3'($urandom_range(0, 7));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      send(rop, ra, rb, model(rop, ra, rb));
    end
    rand_ready = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("rand_drain");
    chk("rand_count", 64'(pops - p0), 64'd10000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
